muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: EX stage holds an M-extension op (aluc[2:0]==3'b001).
REQ-004 SHALL have port op, input, 3 bits: aluc[5:3] encoding.
  - 000 mul, 010 mulh, 100 mulhsu, 110 mulhu
  - 001 div, 011 divu, 101 rem, 111 remu
  - op[0]=1 selects the divide class.
REQ-005 SHALL have port a, input, 32 bits: rs1 operand / dividend.
REQ-006 SHALL have port b, input, 32 bits: rs2 operand / divisor.
REQ-007 SHALL have port flush, input, 1 bit: abort current op (branch/jump redirect).
REQ-008 SHALL have port stall, output, 1 bit: hold IF/ID/EX pipeline registers.
REQ-009 SHALL have port busy, output, 1 bit: state != IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-011 SHALL have port result, output, 32 bits: rd write data.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-013 In IDLE with start=1 and flush=0, SHALL latch a, b, op and leave IDLE at the next edge.
  - op[0]=0: go to MUL.
  - op[0]=1 and b==0: go to DONE.
  - op in {001,101} with a==32'h80000000 and b==32'hFFFFFFFF: go to DONE.
  - otherwise: go to DIV with counter=31.
REQ-014 Cycle numbering: cycle 0 is the start cycle.
  - mul class: MUL in cycle 1, DONE in cycle 2.
  - Normal divide: DIV in cycles 1..32, FIX in cycle 33, DONE in cycle 34.
  - Special-case divide: DONE in cycle 1.
REQ-015 MUL SHALL compute the 64-bit product of 33-bit operands, sign-extended or zero-extended per op.
  - mul: low 32 bits.
  - mulh: high 32 bits, both operands signed.
  - mulhsu: high 32 bits, a signed, b unsigned.
  - mulhu: high 32 bits, both operands unsigned.
REQ-016 DIV SHALL perform one restoring shift-subtract step per cycle on operand magnitudes.
  - div/rem take absolute values of a and b.
  - divu/remu use a and b raw.
  - Counter decrements each cycle; DIV exits to FIX when counter==0.
REQ-017 FIX SHALL apply signs for signed ops.
  - Quotient negated when sign(a) != sign(b).
  - Remainder negated when a is negative.
  - Result selects quotient (div/divu) or remainder (rem/remu).
REQ-018 Divide-by-zero results:
  - div/divu: 32'hFFFFFFFF.
  - rem/remu: a.
REQ-019 Signed-overflow results:
  - div: 32'h80000000.
  - rem: 0.
REQ-020 result SHALL be registered when entering DONE and hold until the next completed op.
REQ-021 done SHALL be 1 exactly while in DONE; DONE SHALL always go to IDLE next cycle.
REQ-022 stall SHALL be (IDLE & start & ~flush) | MUL | DIV | FIX; stall SHALL be 0 in DONE so the pipeline captures result.
REQ-023 start SHALL be ignored in every state except IDLE; this includes the DONE cycle.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge.
  - No done pulse.
  - result unchanged.
REQ-025 flush and start both 1 in IDLE: flush SHALL win; no op is launched and stall=0.

Reset
REQ-026 rst=1 SHALL force the following at the next edge, regardless of state, including mid-divide:
  - state=IDLE, counter=0, result=0.
  - done=0, busy=0, stall=0 (with start=0).
REQ-027 rst SHALL take priority over start and flush in the same cycle.

Verification
REQ-028 mul with a=7, b=32'hFFFFFFFD -> result 32'hFFFFFFEB.
  - done=1 in cycle 2 only; stall=1 in cycles 0-1.
REQ-029 a=b=32'hFFFFFFFF through the mulh family:
  - mulhu -> 32'hFFFFFFFE.
  - mulh -> 32'h00000000.
  - mulhsu -> 32'hFFFFFFFF.
REQ-030 a=-7 (32'hFFFFFFF9), b=2:
  - div -> 32'hFFFFFFFD; rem -> 32'hFFFFFFFF.
  - done in cycle 34; stall=1 in cycles 0-33.
REQ-031 a=5, b=0:
  - divu -> 32'hFFFFFFFF; remu -> 5.
  - done in cycle 1.
  - div with a=32'h80000000, b=32'hFFFFFFFF -> 32'h80000000, done in cycle 1.
  - rem with the same operands -> 0.
REQ-032 Flush and reset during a div, starting with result=32'h12345678:
  - flush in cycle 10 -> busy=0 in cycle 11, no done, result stays 32'h12345678.
  - Repeat with rst in cycle 10 -> result=0, all outputs 0 in cycle 11.
REQ-033 start held high through a mul:
  - Exactly one done pulse, in cycle 2.
  - A new op is launched in cycle 3 (IDLE), with done in cycle 5.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: single-cycle multiply, 32-step restoring divide, sign fixup.
// Latency: mul 2 cycles, divide 34 cycles, div-by-zero/overflow 1 cycle; stall holds the pipeline until DONE.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] a_r, b_r, quo, rem;
    logic [1:0]  op_r;
    logic [4:0]  cnt;
    logic        neg_q, neg_r;

    logic        launch, load_res;
    logic [31:0] res_nxt;

    // Launch-time decode of the incoming operands
    logic        sdiv, a_neg, b_neg, div_zero, div_ovf;
    logic [31:0] a_mag, b_mag, special_res;

    assign launch   = (state == IDLE) && start && !flush;
    assign sdiv     = ~op[1];
    assign a_neg    = sdiv & a[31];
    assign b_neg    = sdiv & b[31];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = (b == 32'd0);
    assign div_ovf  = sdiv && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign special_res = div_zero ? (op[2] ? a : 32'hFFFF_FFFF)
                                  : (op[2] ? 32'd0 : 32'h8000_0000);

    // Multiply: 33-bit operands, sign bit chosen by op, product taken mod 2^64
    logic        a_sx, b_sx;
    logic [63:0] prod;
    logic [31:0] mul_res;

    assign a_sx    = ((op_r == 2'b01) || (op_r == 2'b10)) & a_r[31];
    assign b_sx    = (op_r == 2'b01) & b_r[31];
    assign prod    = $signed({{31{a_sx}}, a_sx, a_r}) * $signed({{31{b_sx}}, b_sx, b_r});
    assign mul_res = (op_r == 2'b00) ? prod[31:0] : prod[63:32];

    // One restoring divide step; remainder stays below the divisor so 32 bits suffice
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_sub, fix_res;

    assign rem_sh  = {rem, quo[31]};
    assign fits    = rem_sh >= {1'b0, b_r};
    assign rem_sub = rem_sh[31:0] - b_r;
    assign fix_res = op_r[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        load_res  = 1'b0;
        res_nxt   = result;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    stall = 1'b1;
                    if (!op[0]) begin
                        state_nxt = MUL;
                    end else if (div_zero || div_ovf) begin
                        state_nxt = DONE;
                        load_res  = 1'b1;
                        res_nxt   = special_res;
                    end else begin
                        state_nxt = DIV;
                    end
                end
            end
            MUL: begin
                stall     = 1'b1;
                state_nxt = DONE;
                load_res  = 1'b1;
                res_nxt   = mul_res;
            end
            DIV: begin
                stall = 1'b1;
                if (cnt == 5'd0) state_nxt = FIX;
            end
            FIX: begin
                stall     = 1'b1;
                state_nxt = DONE;
                load_res  = 1'b1;
                res_nxt   = fix_res;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            load_res  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            result <= 32'd0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            op_r   <= 2'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_res) result <= res_nxt;
            if (launch) begin
                a_r   <= a;
                b_r   <= op[0] ? b_mag : b;
                quo   <= a_mag;
                rem   <= 32'd0;
                op_r  <= op[2:1];
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                cnt   <= op[0] ? 5'd31 : 5'd0;
            end else if (state == DIV) begin
                if (cnt != 5'd0) cnt <= cnt - 5'd1;
                rem <= fits ? rem_sub : rem_sh[31:0];
                quo <= {quo[30:0], fits};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scenario bench for muldiv_sequencer: expected results queued at launch, compared at done.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        stall, busy, done;
    logic [31:0] result;

    int total = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Launch one op in cycle 0, then track it until done or a cycle budget expires
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int cyc;
        bit got;
        logic [31:0] e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(exp_res);
        #1;
        total++;
        if (stall !== 1'b1) $display("FAIL %s stall_c0 got %b want 1", name, stall);
        else passed++;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (done === 1'b1) begin
                got = 1'b1;
                e = exp_q.pop_front();
                total++;
                if (result !== e) $display("FAIL %s result got %h want %h", name, result, e);
                else passed++;
                total++;
                if (cyc != exp_lat) $display("FAIL %s latency got %0d want %0d", name, cyc, exp_lat);
                else passed++;
                total++;
                if (stall !== 1'b0) $display("FAIL %s stall_done got %b want 0", name, stall);
                else passed++;
            end else begin
                total++;
                if (stall !== 1'b1) $display("FAIL %s stall_c%0d got %b want 1", name, cyc, stall);
                else passed++;
            end
        end
        if (!got) begin
            total++;
            $display("FAIL %s timeout got no done want done in cycle %0d", name, exp_lat);
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done, busy);
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({done, busy, stall} !== 3'b000 || result !== 32'd0)
            $display("FAIL reset got d/b/s=%b%b%b result=%h want 000 0", done, busy, stall, result);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul");
        run_op(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, "mulh");
        run_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu");
    endtask

    task automatic test_div;
        run_op(3'b001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_neg");
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_neg");
        run_op(3'b011, 32'd100, 32'd7, 32'd14, 34, "divu");
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu");
        run_op(3'b001, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, "div_negb");
        run_op(3'b101, 32'd20, 32'hFFFF_FFFD, 32'd2, 34, "rem_negb");
    endtask

    task automatic test_special;
        run_op(3'b011, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_zero");
        run_op(3'b111, 32'd5, 32'd0, 32'd5, 1, "remu_zero");
        run_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    endtask

    // Abort a divide in cycle 10 with either flush or rst
    task automatic test_abort(input bit use_rst);
        run_op(3'b000, 32'h1234_5678, 32'd1, 32'h1234_5678, 2, "seed");
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL abort_busy_c10 got %b want 1", busy);
        else passed++;
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        total++;
        if ({busy, done, stall} !== 3'b000)
            $display("FAIL abort_c11 got b/d/s=%b%b%b want 000", busy, done, stall);
        else passed++;
        total++;
        if (result !== (use_rst ? 32'd0 : 32'h1234_5678))
            $display("FAIL abort_result got %h want %h", result, use_rst ? 32'd0 : 32'h1234_5678);
        else passed++;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) begin
                total++;
                $display("FAIL abort_late got done=%b busy=%b want 0 0", done, busy);
            end
        end
    endtask

    task automatic test_flush_start;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        #1;
        total++;
        if (stall !== 1'b0) $display("FAIL flush_start_stall got %b want 0", stall);
        else passed++;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL flush_start_busy got %b want 0", busy);
        else passed++;
    endtask

    // start held high: one op done in cycle 2, relaunch in cycle 3, done in cycle 5
    task automatic test_back_to_back;
        logic [1:0] dseen [1:7];
        logic [31:0] e;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd9;
        exp_q.push_back(32'd54);
        exp_q.push_back(32'd54);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 5) start = 1'b0;
            dseen[c] = {done, busy};
            if (done === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (result !== e) $display("FAIL b2b_result_c%0d got %h want %h", c, result, e);
                else passed++;
            end
            if (c == 3) begin
                total++;
                if (stall !== 1'b1 || busy !== 1'b0)
                    $display("FAIL b2b_relaunch_c3 got stall=%b busy=%b want 1 0", stall, busy);
                else passed++;
            end
        end
        total++;
        if (dseen[1][1] !== 1'b0 || dseen[2][1] !== 1'b1 || dseen[3][1] !== 1'b0 ||
            dseen[4][1] !== 1'b0 || dseen[5][1] !== 1'b1 || dseen[6][1] !== 1'b0 || dseen[7][1] !== 1'b0)
            $display("FAIL b2b_done_pattern got %b%b%b%b%b%b%b want 0100100",
                     dseen[1][1], dseen[2][1], dseen[3][1], dseen[4][1], dseen[5][1], dseen[6][1], dseen[7][1]);
        else passed++;
        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL b2b_pending got %0d results left want 0", exp_q.size());
            exp_q.delete();
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_abort(1'b0);
        test_abort(1'b1);
        test_flush_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
